// File: rtl/led_pattern_seq.sv
// led_pattern_seq: timer-stepped LED patterns (count/scan/blink/fill), active-low drive; optional PWM dimming under LED_SEQ_PWM_EN.
module led_pattern_seq #(
    parameter int WIDTH    = 6,
    parameter int STEP_DIV = 1,
    parameter int DUTY     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             mode_next,
    input  logic             pause,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] led_output
);
    localparam int SW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0] LAST = SW'(STEP_DIV - 1);
    typedef enum logic [1:0] {COUNT, SCAN, BLINK, FILL} mode_t;
    if (WIDTH < 2 || STEP_DIV < 1 || DUTY < 0 || DUTY > 8) begin : g_bad_params
        $error("led_pattern_seq: illegal parameter value");
    end
    mode_t            st, st_n;
    logic [WIDTH-1:0] pat, pat_n, pat_step, pat_scan, pat_entry;
    logic             dir, dir_n, dir_scan, turn, accept, last;
    logic [SW-1:0]    step_cnt, step_cnt_n;
    assign accept = tick && !pause && !mode_next;
    assign last   = step_cnt == LAST;
    assign mode   = st;
    // A scan reverses when it reaches the end it is heading for; the new
    // direction alone decides which way the mask shifts this step.
    always_comb begin
        turn      = dir ? pat[0] : pat[WIDTH-1];
        dir_scan  = dir ^ turn;
        pat_scan  = dir_scan ? pat >> 1 : pat << 1;
        pat_step  = st == COUNT ? pat + WIDTH'(1) :
                    st == SCAN  ? pat_scan :
                    st == BLINK ? ~pat :
                    (&pat ? '0 : {pat[WIDTH-2:0], 1'b1});
        st_n      = mode_next ? mode_t'(st + 2'd1) : st;
        pat_entry = st_n == SCAN ? WIDTH'(1) : st_n == BLINK ? '1 : '0;
        pat_n     = mode_next ? pat_entry : (accept && last) ? pat_step : pat;
        dir_n     = mode_next ? 1'b0 : (accept && last && st == SCAN) ? dir_scan : dir;
        step_cnt_n = mode_next ? '0 : !accept ? step_cnt : last ? '0 : step_cnt + SW'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= COUNT;
            pat      <= '0;
            dir      <= 1'b0;
            step_cnt <= '0;
        end else begin
            st       <= st_n;
            pat      <= pat_n;
            dir      <= dir_n;
            step_cnt <= step_cnt_n;
        end
    end
`ifdef LED_SEQ_PWM_EN
    logic [2:0] pwm_cnt;
    logic       pwm_on;
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            pwm_on  <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 3'd1;
            pwm_on  <= {1'b0, pwm_cnt} < 4'(DUTY);
        end
    end
    assign led_output = ~(pat & {WIDTH{pwm_on}});
`else
    assign led_output = ~pat;
`endif
endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

LED pattern sequencer that consumes the one-cycle overflow/tick pulse produced by the board timer and drives the active-low LED bank. It replaces the plain free-running LED counter with four selectable display patterns: binary count, bouncing scan, blink and thermometer fill. A one-cycle mode-advance pulse selects the pattern, and a pause input freezes stepping. The block sits between the timer and the `led_output` pins in the top level.

## Interface
- `WIDTH`, 6, number of LEDs; legal range ≥ 2.
- `STEP_DIV`, 1, accepted ticks per pattern step; legal range ≥ 1.
- `DUTY`, 4, PWM on-slots out of 8 (0–8); used only when `LED_SEQ_PWM_EN` is defined.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle step pulse from the timer overflow.
- `mode_next`  in  1  one-cycle pulse that advances the mode.
- `pause`  in  1  level input; while high, ticks are ignored.
- `mode`  out  2  current mode: 0 COUNT, 1 SCAN, 2 BLINK, 3 FILL.
- `led_output`  out  WIDTH  active-low LED drive (0 = lit).

## Operation
- Internal state:
  - `pat[WIDTH-1:0]`: lit mask, 1 = lit.
  - `dir`: scan direction, 0 = up.
  - `step_cnt`: range 0..STEP_DIV-1.
  - `mode[1:0]`.
- Accepted tick is `tick && !pause && !mode_next`.
- On an accepted tick:
  - If `step_cnt == STEP_DIV-1`: step the pattern and set `step_cnt` to 0.
  - Otherwise: increment `step_cnt`.
- Step rules by mode:
  - COUNT: `pat <= pat + 1`, modulo 2^WIDTH (all-ones wraps to 0).
  - SCAN, `dir` up: if `pat[WIDTH-1]` is set, then `dir <= down` and `pat <= pat >> 1`; otherwise `pat <= pat << 1`.
  - SCAN, `dir` down: if `pat[0]` is set, then `dir <= up` and `pat <= pat << 1`; otherwise `pat <= pat >> 1`. Endpoints are shown for exactly one step.
  - BLINK: `pat <= ~pat`.
  - FILL: if `pat` is all ones, `pat <= 0`; otherwise `pat <= (pat << 1) | 1`.
- On `mode_next`:
  - `mode <= mode + 1`, wrapping 3 → 0.
  - `step_cnt <= 0` and `dir <= up`.
  - `pat` loads the entry value of the new mode: COUNT 0, SCAN `...0001`, BLINK all ones, FILL 0.
- Simultaneous `mode_next` and `tick`: the mode change wins and the tick is discarded.
- `pause` does not block `mode_next`. A paused `tick` does not advance `step_cnt`.
- `led_output = ~pat`, gated by PWM when that feature is enabled (see Configuration).

## Timing
- Reset values:
  - `mode` = 0, `pat` = 0, `dir` = up, `step_cnt` = 0, PWM counter = 0.
  - `led_output` = all ones (all LEDs off).
- `rst` overrides every other input in the same cycle, including when it arrives mid-pattern or mid-divide.
- Latency: a tick sampled at edge N updates `pat` at edge N. The new `led_output` is visible after edge N; there are no extra pipeline stages.
- `mode_next` sampled at edge N: `mode` and `pat` change at edge N.
- `tick` held high for k cycles counts as k ticks; no edge detection is performed.
- `led_output` and `mode` are driven from registers only, with no combinational path from inputs.

## Configuration
- `LED_SEQ_PWM_EN` defined:
  - A 3-bit free-running counter increments every cycle and wraps at 7 → 0; reset value 0.
  - `pwm_on` is registered and equals `(cnt < DUTY)`.
  - `led_output = ~(pat & {WIDTH{pwm_on}})`.
  - `DUTY` = 0 keeps all LEDs off; `DUTY` = 8 keeps `pwm_on` constantly high.
  - Mode and step behaviour is unchanged.
- `LED_SEQ_PWM_EN` not defined: no PWM counter is built, `DUTY` is ignored, and `led_output = ~pat`.

## Test plan
- Reset, then 3 ticks with STEP_DIV=1, mode COUNT -> `led_output` = 6'b111100. After 64 ticks total -> `pat` wraps to 0 and `led_output` = 6'b111111.
- One `mode_next` -> `mode` = 1, `led_output` = 6'b111110. Then 5 ticks -> 6'b011111; 6th tick -> 6'b101111; 10th tick -> 6'b111110; 11th tick -> 6'b111101.
- In SCAN, assert `tick` and `mode_next` in the same cycle -> `mode` = 2, `led_output` = 6'b000000, tick dropped. Next tick -> 6'b111111.
- STEP_DIV=3, COUNT: 2 ticks -> no change; 3rd tick -> `led_output` = 6'b111110. `pause` high for 10 ticks -> no change. A `mode_next` while paused -> `mode` advances.
- FILL (three `mode_next` from reset): 6 ticks -> `led_output` = 6'b000000; 7th tick -> 6'b111111. Assert `rst` mid-fill -> next cycle `mode` = 0 and `led_output` = 6'b111111.
- With `LED_SEQ_PWM_EN`, DUTY=4, BLINK mode -> each LED pin is low for exactly 4 of every 8 cycles. With DUTY=0 -> all pins stay high.
